// File: rtl/uart_tx_control_unit.sv
// Transmit sequencing FSM: times each bit to the latched prescale, steers the line mux
// through start/data/parity/stop, and tells the serializer when to load and shift.
module uart_tx_control_unit #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                          UCLK,
    input  logic                          reset,
    input  logic                          data_valid,
    input  logic                          parity_en,
    input  logic [5:0]                    prescale,
    output logic                          data_load,
    output logic                          serializer_enable,
    output logic [$clog2(DATA_WIDTH)-1:0] data_index,
    output logic [1:0]                    mux_select,
    output logic                          busy,
    output logic                          tx_done
);
    localparam int IW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_reg, state_next;
    logic [5:0]      cnt_reg, cnt_next;
    logic [5:0]      pre_reg, pre_next;
    logic [5:0]      p_last;
    logic [IW-1:0]   idx_reg, idx_next;
    logic            par_reg, par_next;
    logic            tx_done_reg;
    logic            bit_end;
    logic            accept;
    logic            load;

    // Prescale values below 2 would leave no room for a distinct bit-end cycle.
    always_comb begin
        if (pre_reg < 6'd2) p_last = 6'd1;
        else                p_last = pre_reg - 6'd1;
    end

    assign bit_end = (cnt_reg == p_last);
    assign accept  = (state_reg == IDLE) || ((state_reg == STOP) && bit_end);
    assign load    = accept && data_valid && !reset;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        pre_next   = pre_reg;
        par_next   = par_reg;
        if (state_reg != IDLE) begin
            cnt_next = bit_end ? 6'd0 : cnt_reg + 6'd1;
        end
        case (state_reg)
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_reg == IW'(DATA_WIDTH - 1)) begin
                        idx_next   = '0;
                        state_next = par_reg ? PARITY : STOP;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
            default: state_next = state_reg;
        endcase
        // A load in the last STOP cycle overrides the return to IDLE (back-to-back frames).
        if (load) begin
            state_next = START;
            cnt_next   = '0;
            idx_next   = '0;
            pre_next   = prescale;
            par_next   = parity_en;
        end
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            pre_reg     <= '0;
            par_reg     <= 1'b0;
            tx_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            pre_reg     <= pre_next;
            par_reg     <= par_next;
            tx_done_reg <= (state_reg == STOP) && bit_end;
        end
    end

    always_comb begin
        case (state_reg)
            START:   mux_select = 2'b00;
            DATA:    mux_select = 2'b01;
            PARITY:  mux_select = 2'b10;
            default: mux_select = 2'b11;
        endcase
    end

    assign busy              = (state_reg != IDLE);
    assign serializer_enable = (state_reg == DATA) && bit_end;
    assign data_index        = idx_reg;
    assign data_load         = load;
    assign tx_done           = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_control_unit.sv
// Directed bench for uart_tx_control_unit: walks frames cycle by cycle against
// hand-derived bit timing for 8-bit frames.
module tb_uart_tx_control_unit;
    logic       UCLK = 1'b0;
    logic       reset = 1'b0;
    logic       data_valid = 1'b0;
    logic       parity_en = 1'b0;
    logic [5:0] prescale = 6'd0;
    logic       data_load;
    logic       serializer_enable;
    logic [2:0] data_index;
    logic [1:0] mux_select;
    logic       busy;
    logic       tx_done;

    int pass_cnt = 0;
    int total_cnt = 0;

    uart_tx_control_unit #(.DATA_WIDTH(8)) dut (
        .UCLK              (UCLK),
        .reset             (reset),
        .data_valid        (data_valid),
        .parity_en         (parity_en),
        .prescale          (prescale),
        .data_load         (data_load),
        .serializer_enable (serializer_enable),
        .data_index        (data_index),
        .mux_select        (mux_select),
        .busy              (busy),
        .tx_done           (tx_done)
    );

    always #5 UCLK = ~UCLK;

    // Request a frame from IDLE; caller is mid-cycle. Checks same-cycle data_load.
    task automatic start_frame(input logic [5:0] pre, input logic par, input string tag);
        prescale   = pre;
        parity_en  = par;
        data_valid = 1'b1;
        #1;
        total_cnt++;
        if (data_load !== 1'b1) $display("FAIL %s load_req: data_load=%b expected 1", tag, data_load);
        else pass_cnt++;
    endtask

    // Steps cycles 0..L-1 of a frame loaded on the previous edge.
    task automatic run_frame(input int pe, input bit par, input bit done_at0,
                             input int dv_pulse, input int cfg_cyc, input bit hold,
                             input string tag);
        int L;
        int sen_cnt;
        logic [1:0] e_mux;
        logic       e_sen;
        logic [2:0] e_idx;
        logic       e_done;
        logic       e_load;
        L = (10 + (par ? 1 : 0)) * pe;
        sen_cnt = 0;
        for (int c = 0; c < L; c++) begin
            @(posedge UCLK);
            #1;
            data_valid = hold || (c == dv_pulse);
            if (c == cfg_cyc) begin
                prescale  = 6'd16;
                parity_en = 1'b1;
            end
            #1;
            if (c < pe)                 e_mux = 2'b00;
            else if (c < 9 * pe)        e_mux = 2'b01;
            else if (par && c < 10 * pe) e_mux = 2'b10;
            else                        e_mux = 2'b11;
            e_sen  = (c >= pe) && (c < 9 * pe) && ((c % pe) == pe - 1);
            e_idx  = (c >= pe && c < 9 * pe) ? 3'((c - pe) / pe) : 3'd0;
            e_done = (c == 0) && done_at0;
            e_load = (c == L - 1) && data_valid;
            if (serializer_enable === 1'b1) sen_cnt++;
            total_cnt++;
            if (mux_select !== e_mux) $display("FAIL %s mux c=%0d: got %b expected %b", tag, c, mux_select, e_mux);
            else pass_cnt++;
            total_cnt++;
            if (serializer_enable !== e_sen) $display("FAIL %s ser_en c=%0d: got %b expected %b", tag, c, serializer_enable, e_sen);
            else pass_cnt++;
            total_cnt++;
            if (data_index !== e_idx) $display("FAIL %s index c=%0d: got %0d expected %0d", tag, c, data_index, e_idx);
            else pass_cnt++;
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL %s busy c=%0d: got %b expected 1", tag, c, busy);
            else pass_cnt++;
            total_cnt++;
            if (tx_done !== e_done) $display("FAIL %s tx_done c=%0d: got %b expected %b", tag, c, tx_done, e_done);
            else pass_cnt++;
            total_cnt++;
            if (data_load !== e_load) $display("FAIL %s data_load c=%0d: got %b expected %b", tag, c, data_load, e_load);
            else pass_cnt++;
        end
        total_cnt++;
        if (sen_cnt !== 8) $display("FAIL %s ser_en_count: got %0d expected 8", tag, sen_cnt);
        else pass_cnt++;
        $display("%s: frame of %0d cycles stepped, %0d shift pulses", tag, L, sen_cnt);
    endtask

    // Cycle L: tx_done pulse and return to idle; cycle L+1: pulse gone.
    task automatic finish_frame(input string tag);
        @(posedge UCLK);
        #1;
        data_valid = 1'b0;
        #1;
        total_cnt++;
        if (tx_done !== 1'b1) $display("FAIL %s done_pulse: tx_done=%b expected 1", tag, tx_done);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || mux_select !== 2'b11) $display("FAIL %s idle_after: busy=%b mux=%b expected 0/11", tag, busy, mux_select);
        else pass_cnt++;
        @(posedge UCLK);
        #2;
        total_cnt++;
        if (tx_done !== 1'b0) $display("FAIL %s done_single: tx_done=%b expected 0", tag, tx_done);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        data_valid = 1'b1;
        #2;
        total_cnt++;
        if (mux_select !== 2'b11 || busy !== 1'b0 || tx_done !== 1'b0 ||
            serializer_enable !== 1'b0 || data_load !== 1'b0 || data_index !== 3'd0)
            $display("FAIL reset_state: mux=%b busy=%b done=%b sen=%b load=%b idx=%0d expected 11/0/0/0/0/0",
                     mux_select, busy, tx_done, serializer_enable, data_load, data_index);
        else pass_cnt++;
        @(posedge UCLK);
        #1;
        reset = 1'b0;
        data_valid = 1'b0;
        #1;
        $display("test_reset: done");
    endtask

    task automatic test_8n1();
        start_frame(6'd16, 1'b0, "8n1_p16");
        run_frame(16, 1'b0, 1'b0, -1, -1, 1'b0, "8n1_p16");
        finish_frame("8n1_p16");
    endtask

    task automatic test_8e1();
        start_frame(6'd8, 1'b1, "8e1_p8");
        run_frame(8, 1'b1, 1'b0, -1, -1, 1'b0, "8e1_p8");
        finish_frame("8e1_p8");
    endtask

    task automatic test_back_to_back();
        start_frame(6'd8, 1'b0, "b2b");
        run_frame(8, 1'b0, 1'b0, -1, -1, 1'b1, "b2b_f1");
        run_frame(8, 1'b0, 1'b1, -1, -1, 1'b0, "b2b_f2");
        finish_frame("b2b_f2");
    endtask

    task automatic test_config_change();
        start_frame(6'd8, 1'b0, "cfg_f1");
        run_frame(8, 1'b0, 1'b0, -1, 20, 1'b0, "cfg_f1");
        finish_frame("cfg_f1");
        start_frame(6'd16, 1'b1, "cfg_f2");
        run_frame(16, 1'b1, 1'b0, -1, -1, 1'b0, "cfg_f2");
        finish_frame("cfg_f2");
    endtask

    task automatic test_reset_mid_frame();
        start_frame(6'd8, 1'b0, "rst_mid");
        for (int c = 0; c <= 37; c++) begin
            @(posedge UCLK);
            #1;
            data_valid = 1'b0;
        end
        #1;
        total_cnt++;
        if (mux_select !== 2'b01 || data_index !== 3'd3)
            $display("FAIL rst_mid pre_reset: mux=%b idx=%0d expected 01/3", mux_select, data_index);
        else pass_cnt++;
        reset = 1'b1;
        data_valid = 1'b1;
        #1;
        total_cnt++;
        if (mux_select !== 2'b11 || busy !== 1'b0 || data_index !== 3'd0 || data_load !== 1'b0)
            $display("FAIL rst_mid same_cycle: mux=%b busy=%b idx=%0d load=%b expected 11/0/0/0",
                     mux_select, busy, data_index, data_load);
        else pass_cnt++;
        @(posedge UCLK);
        @(posedge UCLK);
        #1;
        reset = 1'b0;
        data_valid = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || tx_done !== 1'b0) $display("FAIL rst_mid released: busy=%b done=%b expected 0/0", busy, tx_done);
        else pass_cnt++;
        start_frame(6'd8, 1'b0, "rst_clean");
        run_frame(8, 1'b0, 1'b0, -1, -1, 1'b0, "rst_clean");
        finish_frame("rst_clean");
    endtask

    task automatic test_small_prescale();
        start_frame(6'd0, 1'b0, "pre0");
        run_frame(2, 1'b0, 1'b0, -1, -1, 1'b0, "pre0");
        finish_frame("pre0");
        start_frame(6'd1, 1'b0, "pre1");
        run_frame(2, 1'b0, 1'b0, -1, -1, 1'b0, "pre1");
        finish_frame("pre1");
    endtask

    task automatic test_ignored_request();
        start_frame(6'd8, 1'b0, "dv_mid");
        run_frame(8, 1'b0, 1'b0, 30, -1, 1'b0, "dv_mid");
        finish_frame("dv_mid");
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_8e1();
        test_back_to_back();
        test_config_change();
        test_reset_mid_frame();
        test_small_prescale();
        test_ignored_request();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_control_unit.md
# uart_tx_control_unit

Sequencing FSM for the UART transmitter datapath.

- Accepts a frame request from the APB-side register block.
- Times every bit to `prescale` UCLK cycles.
- Steers the datapath output mux through start, data, optional parity and stop bits, and tells the serializer when to load and shift.
- Transmit-side counterpart of the receiver control unit. Owns its own per-bit cycle counter and bit index; no external edge counter.

## Interface

Parameters
- `DATA_WIDTH`, default 8: data bits per frame, ≥2.

Ports
- `UCLK`, input, 1: UART clock. All state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `data_valid`, input, 1: frame request. Sampled only when the block can accept (see Operation).
- `parity_en`, input, 1: include a parity bit. Latched at frame load.
- `prescale`, input, 6: UCLK cycles per bit. Latched at frame load.
- `data_load`, output, 1: combinational. Datapath captures P_DATA and computes parity this cycle.
- `serializer_enable`, output, 1: one-cycle pulse in the last cycle of each data bit. Datapath shifts on this pulse.
- `data_index`, output, $clog2(DATA_WIDTH): index of the data bit currently on the line.
- `mux_select`, output, 2: line source. 00 = start (0), 01 = data, 10 = parity, 11 = stop/idle (1).
- `busy`, output, 1: high while a frame is in progress.
- `tx_done`, output, 1: registered one-cycle pulse after a frame's stop bit completes.

## Operation

States: IDLE, START, DATA, PARITY, STOP. Outputs are Moore-decoded from the registered state, except `data_load`.

- Reset (asynchronous, any state, mid-frame included):
  - state = IDLE; cycle counter, bit index and latched config cleared.
  - `mux_select` = 11; `busy`, `tx_done`, `serializer_enable`, `data_load`, `data_index` = 0.
  - The line returns high on the cycle reset asserts. A partial frame is abandoned, not resumed.
- Accept window: IDLE, or the last cycle of STOP.
  - In the window, `data_valid` = 1 drives `data_load` = 1 in the same cycle.
  - On that edge the block latches `prescale`/`parity_en`, clears counters and enters START.
  - `data_valid` outside the window is ignored; no queueing.
- Effective prescale P = latched `prescale`, except 0 and 1 are treated as 2.
  - The cycle counter runs 0..P-1 in every bit state.
  - "Bit end" means counter == P-1. The counter wraps to 0 there.
- START: `mux_select` = 00. At bit end go to DATA with index 0.
- DATA: `mux_select` = 01; `data_index` = bit index.
  - At bit end: `serializer_enable` = 1 and the index increments.
  - When index == DATA_WIDTH-1 at bit end, go to PARITY if latched `parity_en`, else STOP. The index returns to 0.
- PARITY: `mux_select` = 10. At bit end go to STOP.
- STOP: `mux_select` = 11.
  - At bit end, `tx_done` pulses on the following cycle.
  - Next state is START if `data_valid` = 1 (back-to-back, no idle bit), else IDLE.
- `busy` = 1 in START, DATA, PARITY, STOP.
- Changes to `prescale`/`parity_en` mid-frame have no effect until the next load.

## Timing

- Load on edge 0 (`data_valid` high in IDLE before edge 0):
  - `mux_select` = 00 and `busy` = 1 from edge 0.
  - Frame occupies (2 + DATA_WIDTH + parity_en)·P cycles.
  - `tx_done` is high for exactly one cycle, beginning at the edge that ends STOP.
- Back-to-back load in the last STOP cycle:
  - `tx_done` pulses and `mux_select` goes 11→00 on the same edge.
  - `busy` stays 1 continuously.
- `serializer_enable` fires DATA_WIDTH times per frame, each P cycles apart. The first pulse is at cycle 2P-1 after load.
- Counter width: 6 bits; compare against P-1 computed in 6 bits. P = 63 (max) is legal.

## Test plan

- 8N1, `prescale` = 16, one request:
  - `busy` high for 160 cycles; start 16 cycles at 00; 8 data bits at 01 with `data_index` 0..7.
  - 8 `serializer_enable` pulses at cycles 31, 47, …, 143; stop 16 cycles; `tx_done` single pulse at cycle 160.
- 8E1, `prescale` = 8: frame is 88 cycles; `mux_select` = 10 for cycles 72–79; `tx_done` at 88.
- Back-to-back: `data_valid` held high, `prescale` = 8, no parity.
  - Two frames of 80 cycles, `busy` never drops; second `data_load` in cycle 79; `tx_done` pulses at 80 and 160.
- Config change mid-frame: load with `prescale` = 8, switch to 16 and `parity_en` = 1 at cycle 20.
  - Frame still 80 cycles, no parity state; next frame 176 cycles.
- Reset at cycle 37 of an 8N1 `prescale` = 8 frame:
  - Same cycle: `mux_select` = 11, `busy` = 0, `data_index` = 0.
  - After release, a new request produces a clean full frame.
- `prescale` = 0 and `prescale` = 1: each bit lasts 2 cycles; 8N1 frame = 20 cycles.
- `data_valid` pulsed mid-DATA: ignored; no extra `data_load`; frame length unchanged.
